// File: rtl/mdl_pgrx_pkg.sv
// Shared definitions for the page-register serial link (receiver and serializer sides).
package mdl_pgrx_pkg;

  localparam int PGW_DEF    = 12;
  localparam int SLOT_OPEN  = 0;
  localparam int SLOT_CLOSE = 12;
  localparam int ROT_W      = 20;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } pg_state_e;

  // The bit counter sticks at its maximum so that an overrun can never alias
  // back to a legal count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(CNT_MAX)) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mdl_pgrx_if.sv
// Timing, serial data and page result bundle for the page receiver.
interface mdl_pgrx_if
  import mdl_pgrx_pkg::*;
#(
  parameter int PGW = PGW_DEF
);
  logic             i_CLK2M_PCEN_n;
  logic [ROT_W-1:0] i_ROT20_n;
  logic             i_RX_EN;
  logic             i_SDI;
  logic [PGW-1:0]   i_TARGET;
  logic [PGW-1:0]   o_PAGE;
  logic             o_PG_VALID;
  logic             o_PG_MATCH;
  logic             o_PG_ERR;
  logic             o_BUSY;

  modport slave (
    input  i_CLK2M_PCEN_n, i_ROT20_n, i_RX_EN, i_SDI, i_TARGET,
    output o_PAGE, o_PG_VALID, o_PG_MATCH, o_PG_ERR, o_BUSY
  );

  modport master (
    output i_CLK2M_PCEN_n, i_ROT20_n, i_RX_EN, i_SDI, i_TARGET,
    input  o_PAGE, o_PG_VALID, o_PG_MATCH, o_PG_ERR, o_BUSY
  );
endinterface

// File: rtl/mdl_pgrx_sipo.sv
// Serial-in parallel-out page register, LSB first, with a saturating bit counter.
module mdl_pgrx_sipo
  import mdl_pgrx_pkg::*;
#(
  parameter int PGW = PGW_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_sdi,
  output logic [PGW-1:0]   o_word,
  output logic [CNT_W-1:0] o_cnt
);

  logic [PGW-1:0]   r_sr;
  logic [CNT_W-1:0] r_cnt;

  // New bits enter at the MSB so the first (LSB) bit lands in bit 0 after PGW shifts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (i_shift) begin
        r_sr  <= {i_sdi, r_sr[PGW-1:1]};
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  assign o_word = r_sr;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/mdl_pgrx.sv
// Page receiver: captures a serial page in the slot 0..12 window and compares it to a target.
module mdl_pgrx
  import mdl_pgrx_pkg::*;
#(
  parameter int PGW = PGW_DEF
) (
  input  logic        i_MCLK,
  input  logic        i_SYS_RST,
  mdl_pgrx_if.slave   bus
);

  pg_state_e        r_state, w_nxt;
  logic             w_en, w_open, w_close;
  logic             w_clr, w_shift, w_ok;
  logic [PGW-1:0]   w_word;
  logic [CNT_W-1:0] w_cnt;
  logic [PGW-1:0]   r_page;
  logic             r_valid, r_match, r_err, r_ill;

  assign w_en    = ~bus.i_CLK2M_PCEN_n;
  assign w_open  = ~bus.i_ROT20_n[SLOT_OPEN];
  assign w_close = ~bus.i_ROT20_n[SLOT_CLOSE];
  assign w_ok    = (w_cnt == CNT_W'(PGW)) && !r_ill;

  mdl_pgrx_sipo #(.PGW(PGW)) u_sipo (
    .i_clk   (i_MCLK),
    .i_rst   (i_SYS_RST),
    .i_en    (w_en),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_sdi   (bus.i_SDI),
    .o_word  (w_word),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge i_MCLK or posedge i_SYS_RST) begin
    if (i_SYS_RST) r_state <= ST_IDLE;
    else if (w_en) r_state <= w_nxt;
  end

  // Dropping the arm request only aborts before the window opens; once shifting,
  // the window always runs to its close.
  always_comb begin
    w_nxt   = r_state;
    w_clr   = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.i_RX_EN) w_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!bus.i_RX_EN) w_nxt = ST_IDLE;
        else if (w_open) begin
          w_nxt = ST_SHIFT;
          w_clr = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_close) w_nxt = ST_DONE;
      end
      ST_DONE:  w_nxt = bus.i_RX_EN ? ST_ARMED : ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  // An error from the window just closed wins over the clear that re-arming implies.
  always_ff @(posedge i_MCLK or posedge i_SYS_RST) begin
    if (i_SYS_RST) begin
      r_page  <= '0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
      r_err   <= 1'b0;
      r_ill   <= 1'b0;
    end else if (w_en) begin
      r_valid <= 1'b0;
      if (r_state == ST_SHIFT) r_ill <= w_open & w_close;
      if (r_state == ST_IDLE && w_nxt == ST_ARMED) r_err <= 1'b0;
      if (r_state == ST_DONE) begin
        if (w_ok) begin
          r_page  <= w_word;
          r_match <= (w_word == bus.i_TARGET);
          r_valid <= 1'b1;
          if (w_nxt == ST_ARMED) r_err <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.o_PAGE     = r_page;
  assign bus.o_PG_VALID = r_valid;
  assign bus.o_PG_MATCH = r_match;
  assign bus.o_PG_ERR   = r_err;
  assign bus.o_BUSY     = (r_state == ST_ARMED) || (r_state == ST_SHIFT);

endmodule

// File: tb/tb_mdl_pgrx.sv
// Scoreboard bench for mdl_pgrx: rotations are driven slot by slot, expected results queued per window.
module tb_mdl_pgrx;
  import mdl_pgrx_pkg::*;

  localparam int PGW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdl_pgrx_if #(.PGW(PGW)) bus ();

  mdl_pgrx #(.PGW(PGW)) dut (
    .i_MCLK    (clk),
    .i_SYS_RST (rst),
    .bus       (bus)
  );

  typedef struct {
    bit             is_err;
    logic [PGW-1:0] page;
    logic           match;
  } exp_t;

  exp_t           sbq[$];
  int             vq[$];
  int             n_chk  = 0;
  int             n_fail = 0;
  int             en_cnt = 0;
  logic [PGW-1:0] m_page = '0;
  logic           m_match = 1'b0;
  logic [PGW-1:0] tgt = '0;
  logic           mon_en;
  logic           v_was = 1'b0;
  logic           e_was = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // One enabled MCLK edge per call, preceded by a random number of disabled cycles.
  task automatic en_edge(input logic [ROT_W-1:0] rot, input logic sdi, input logic rx);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(negedge clk);
      bus.i_CLK2M_PCEN_n = 1'b1;
    end
    @(negedge clk);
    bus.i_CLK2M_PCEN_n = 1'b0;
    bus.i_ROT20_n      = rot;
    bus.i_SDI          = sdi;
    bus.i_RX_EN        = rx;
  endtask

  task automatic en_off();
    @(negedge clk);
    bus.i_CLK2M_PCEN_n = 1'b1;
  endtask

  task automatic idle_edges(input int n, input logic rx);
    repeat (n) en_edge('1, 1'($urandom), rx);
  endtask

  // exp_kind: 0 = page completes, 1 = window error, 2 = no visible result.
  // close_at: slot whose edge also drives slot 12 low; -1 means no close at all.
  task automatic rotation(input logic [PGW-1:0] p, input int close_at, input logic rx, input int exp_kind);
    exp_t e;
    if (exp_kind == 0) begin
      e.is_err = 1'b0; e.page = p; e.match = (p == tgt);
      sbq.push_back(e);
      m_page = p; m_match = e.match;
    end else if (exp_kind == 1) begin
      e.is_err = 1'b1; e.page = m_page; e.match = m_match;
      sbq.push_back(e);
    end
    for (int s = 0; s < ROT_W; s++) begin
      logic [ROT_W-1:0] r;
      r = '1;
      r[s] = 1'b0;
      if (s == SLOT_CLOSE && close_at != SLOT_CLOSE) r[SLOT_CLOSE] = 1'b1;
      if (s == close_at) r[SLOT_CLOSE] = 1'b0;
      en_edge(r, (s >= 1 && s <= PGW) ? p[s-1] : 1'($urandom), rx);
    end
  endtask

  task automatic pop_cmp(input bit is_err);
    exp_t e;
    chk("sb_has_entry", (sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("event_kind", e.is_err, is_err);
      chk("page", bus.o_PAGE, e.page);
      chk("match", bus.o_PG_MATCH, e.match);
      if (is_err) chk("valid_on_err", bus.o_PG_VALID, 0);
      else        chk("err_on_valid", bus.o_PG_ERR, 0);
    end
  endtask

  // Monitor: looks at outputs just after each enabled edge.
  always @(posedge clk) begin
    mon_en = ~bus.i_CLK2M_PCEN_n;
    #1;
    if (rst) begin
      v_was = 1'b0;
      e_was = 1'b0;
    end else if (mon_en) begin
      en_cnt++;
      if (v_was) chk("valid_one_period", bus.o_PG_VALID, 0);
      if (bus.o_PG_VALID && !v_was) begin
        vq.push_back(en_cnt);
        pop_cmp(1'b0);
      end
      if (bus.o_PG_ERR && !e_was) pop_cmp(1'b1);
      v_was = bus.o_PG_VALID;
      e_was = bus.o_PG_ERR;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PGW-1:0] p;
    bus.i_CLK2M_PCEN_n = 1'b1;
    bus.i_ROT20_n      = '1;
    bus.i_RX_EN        = 1'b0;
    bus.i_SDI          = 1'b0;
    bus.i_TARGET       = tgt;
    #1 rst = 1'b1;
    #10;
    chk("rst_page",  bus.o_PAGE, 0);
    chk("rst_valid", bus.o_PG_VALID, 0);
    chk("rst_match", bus.o_PG_MATCH, 0);
    chk("rst_err",   bus.o_PG_ERR, 0);
    chk("rst_busy",  bus.o_BUSY, 0);
    @(negedge clk) rst = 1'b0;

    // Matching page
    tgt = 12'hA5C; bus.i_TARGET = tgt;
    idle_edges(2, 1'b0);
    idle_edges(1, 1'b1);
    en_off();
    chk("busy_armed", bus.o_BUSY, 1);
    rotation(12'hA5C, 12, 1'b1, 0);

    // Same stream, different target
    idle_edges(2, 1'b0);
    tgt = 12'hA5D; bus.i_TARGET = tgt;
    idle_edges(1, 1'b1);
    rotation(12'hA5C, 12, 1'b1, 0);

    // Early close after 8 samples
    idle_edges(2, 1'b0);
    idle_edges(1, 1'b1);
    rotation(12'h3C3, 8, 1'b1, 1);
    idle_edges(2, 1'b0);
    en_off();
    chk("err_sticky", bus.o_PG_ERR, 1);
    chk("page_kept",  bus.o_PAGE, 12'hA5C);
    idle_edges(1, 1'b1);
    en_off();
    chk("err_clear_on_arm", bus.o_PG_ERR, 0);

    // Two back-to-back rotations with the arm held
    rotation(12'h001, 12, 1'b1, 0);
    rotation(12'hFFF, 12, 1'b1, 0);
    idle_edges(2, 1'b0);
    en_off();
    chk("page_last", bus.o_PAGE, 12'hFFF);
    chk("valid_spacing", (vq.size() >= 2) ? (vq[vq.size()-1] - vq[vq.size()-2]) : 0, 20);

    // Reset in the middle of a window
    idle_edges(1, 1'b1);
    for (int s = 0; s <= 5; s++) begin
      logic [ROT_W-1:0] r;
      r = '1; r[s] = 1'b0;
      en_edge(r, 1'($urandom), 1'b1);
    end
    en_off();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_page",  bus.o_PAGE, 0);
    chk("mid_rst_valid", bus.o_PG_VALID, 0);
    chk("mid_rst_match", bus.o_PG_MATCH, 0);
    chk("mid_rst_err",   bus.o_PG_ERR, 0);
    chk("mid_rst_busy",  bus.o_BUSY, 0);
    m_page = '0; m_match = 1'b0;
    @(negedge clk) rst = 1'b0;
    for (int s = 6; s < ROT_W; s++) begin
      logic [ROT_W-1:0] r;
      r = '1; r[s] = 1'b0;
      en_edge(r, 1'($urandom), 1'b1);
    end
    rotation(12'h5A7, 12, 1'b1, 0);

    // Arm dropped before slot 0
    idle_edges(2, 1'b0);
    idle_edges(2, 1'b1);
    idle_edges(2, 1'b0);
    en_off();
    chk("abort_busy", bus.o_BUSY, 0);
    rotation(12'h777, 12, 1'b0, 2);
    en_off();
    chk("abort_no_capture", bus.o_PAGE, 12'h5A7);

    // Missed close: count saturates, error at the next slot-12 close
    idle_edges(1, 1'b1);
    rotation(12'h123, -1, 1'b1, 2);
    rotation(12'h456, 12, 1'b1, 1);
    idle_edges(2, 1'b0);
    en_off();
    chk("sat_err", bus.o_PG_ERR, 1);
    idle_edges(1, 1'b1);
    en_off();
    chk("sat_err_clear", bus.o_PG_ERR, 0);

    // Slot 0 and slot 12 together while shifting
    rotation(12'h0F0, -1, 1'b1, 2);
    rotation(12'h0F0, 0, 1'b1, 1);
    idle_edges(2, 1'b0);
    en_off();
    chk("illegal_err", bus.o_PG_ERR, 1);
    idle_edges(1, 1'b1);
    en_off();
    chk("illegal_err_clear", bus.o_PG_ERR, 0);

    // Random pages and targets
    for (int k = 0; k < 6; k++) begin
      idle_edges(2, 1'b0);
      p = PGW'($urandom);
      tgt = ($urandom_range(0, 1) == 1) ? p : PGW'($urandom);
      bus.i_TARGET = tgt;
      idle_edges(1, 1'b1);
      rotation(p, 12, 1'b1, 0);
    end

    idle_edges(3, 1'b0);
    en_off();
    repeat (4) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
